fft_twiddle_stage: RTL and testbench

Pipelined twiddle-multiply stage that sits directly downstream of the radix-2 butterfly (`bfu`). Each cycle it accepts one butterfly output pair. The upper leg (Ya) passes through delay-matched. The lower leg (Yb) is multiplied by the twiddle factor W_N^k, taken from an internal ROM. The result goes to the next FFT stage over a valid/ready handshake with full backpressure.

---
 rtl/fft_twiddle_stage.sv | 214 +++++++++++++++++++++
 tb/tb_fft_twiddle_stage.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_twiddle_stage.sv
// Twiddle-multiply stage behind the radix-2 butterfly: the lower leg is multiplied by W_N^k
// from an internal ROM, the upper leg is delay-matched, and the result leaves over valid/ready.
module fft_twiddle_stage #(
    parameter int N      = 8,
    parameter int STRIDE = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       frame_start,
    input  logic [15:0]                in_ar,
    input  logic [15:0]                in_ai,
    input  logic [15:0]                in_br,
    input  logic [15:0]                in_bi,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [15:0]                out_ar,
    output logic [15:0]                out_ai,
    output logic [15:0]                out_br,
    output logic [15:0]                out_bi,
    output logic [$clog2(N/2)-1:0]     out_k
);

    localparam int HALF      = N / 2;
    localparam int KW        = $clog2(HALF);
    // The ROM is stored at N=16 resolution; an N=8 index selects every other entry.
    localparam int ROM_SHIFT = (N == 8) ? 1 : 0;

    // {wr, wi} for twiddle index k, Q1.15 with 32767 as unity.
    function automatic logic [31:0] twiddle_rom(input logic [KW-1:0] k);
        logic [2:0]  idx;
        logic [31:0] w;
        idx = 3'(k) << ROM_SHIFT;
        case (idx)
            3'd0:    w = {16'sd32767,  16'sd0};
            3'd1:    w = {16'sd30273, -16'sd12539};
            3'd2:    w = {16'sd23170, -16'sd23170};
            3'd3:    w = {16'sd12539, -16'sd30273};
            3'd4:    w = {16'sd0,     -16'sd32767};
            3'd5:    w = {-16'sd12539, -16'sd30273};
            3'd6:    w = {-16'sd23170, -16'sd23170};
            3'd7:    w = {-16'sd30273, -16'sd12539};
            default: w = {16'sd32767,  16'sd0};
        endcase
        return w;
    endfunction

    // Clamp a rounded, rescaled sum into the signed 16-bit range.
    function automatic logic [15:0] sat16(input logic signed [32:0] v);
        logic [15:0] r;
        if (v > 33'sd32767) begin
            r = 16'h7fff;
        end else if (v < -33'sd32768) begin
            r = 16'h8000;
        end else begin
            r = v[15:0];
        end
        return r;
    endfunction

    logic                 advance_s;
    logic                 accept_s;
    logic [KW-1:0]        k_r;
    logic [KW-1:0]        k_use_s;
    logic [KW-1:0]        k_next_s;
    logic [31:0]          w_s;

    logic                 s1_valid_r;
    logic [15:0]          s1_ar_r, s1_ai_r;
    logic signed [15:0]   s1_br_r, s1_bi_r, s1_wr_r, s1_wi_r;
    logic [KW-1:0]        s1_k_r;

    logic signed [31:0]   p_brwr_s, p_biwi_s, p_brwi_s, p_biwr_s;
    logic                 s2_valid_r;
    logic [15:0]          s2_ar_r, s2_ai_r;
    logic signed [31:0]   s2_brwr_r, s2_biwi_r, s2_brwi_r, s2_biwr_r;
    logic [KW-1:0]        s2_k_r;

    logic signed [32:0]   re_s, im_s, re_rnd_s, im_rnd_s, re_sh_s, im_sh_s;
    logic [15:0]          res_br_s, res_bi_s;

    logic                 out_valid_r;
    logic [15:0]          out_ar_r, out_ai_r, out_br_r, out_bi_r;
    logic [KW-1:0]        out_k_r;

    // The whole pipe moves as one unit whenever the output slot is free or draining.
    assign advance_s = !out_valid_r || out_ready;
    assign accept_s  = in_valid && advance_s;
    assign in_ready  = advance_s;

    assign out_valid = out_valid_r;
    assign out_ar    = out_ar_r;
    assign out_ai    = out_ai_r;
    assign out_br    = out_br_r;
    assign out_bi    = out_bi_r;
    assign out_k     = out_k_r;

    // Twiddle index selection; frame_start forces index 0 and wins over wrap-around.
    always_comb begin
        k_use_s  = {KW{1'b0}};
        k_next_s = {KW{1'b0}};
        if (frame_start) begin
            k_use_s = {KW{1'b0}};
        end else begin
            k_use_s = k_r;
        end
        k_next_s = k_use_s + KW'(STRIDE);
        w_s      = twiddle_rom(k_use_s);
    end

    // Index counter steps only on an accepted pair.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_r <= {KW{1'b0}};
        end else if (accept_s) begin
            k_r <= k_next_s;
        end else begin
            k_r <= k_r;
        end
    end

    // S1: capture the pair, its index and the ROM word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
            s1_ar_r    <= 16'd0;
            s1_ai_r    <= 16'd0;
            s1_br_r    <= 16'sd0;
            s1_bi_r    <= 16'sd0;
            s1_wr_r    <= 16'sd0;
            s1_wi_r    <= 16'sd0;
            s1_k_r     <= {KW{1'b0}};
        end else if (advance_s) begin
            s1_valid_r <= in_valid;
            if (in_valid) begin
                s1_ar_r <= in_ar;
                s1_ai_r <= in_ai;
                s1_br_r <= in_br;
                s1_bi_r <= in_bi;
                s1_wr_r <= w_s[31:16];
                s1_wi_r <= w_s[15:0];
                s1_k_r  <= k_use_s;
            end
        end
    end

    // Four partial products of the complex multiply.
    always_comb begin
        p_brwr_s = 32'(s1_br_r) * 32'(s1_wr_r);
        p_biwi_s = 32'(s1_bi_r) * 32'(s1_wi_r);
        p_brwi_s = 32'(s1_br_r) * 32'(s1_wi_r);
        p_biwr_s = 32'(s1_bi_r) * 32'(s1_wr_r);
    end

    // S2: register the products alongside the delayed upper leg.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_r <= 1'b0;
            s2_ar_r    <= 16'd0;
            s2_ai_r    <= 16'd0;
            s2_brwr_r  <= 32'sd0;
            s2_biwi_r  <= 32'sd0;
            s2_brwi_r  <= 32'sd0;
            s2_biwr_r  <= 32'sd0;
            s2_k_r     <= {KW{1'b0}};
        end else if (advance_s) begin
            s2_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                s2_ar_r   <= s1_ar_r;
                s2_ai_r   <= s1_ai_r;
                s2_brwr_r <= p_brwr_s;
                s2_biwi_r <= p_biwi_s;
                s2_brwi_r <= p_brwi_s;
                s2_biwr_r <= p_biwr_s;
                s2_k_r    <= s1_k_r;
            end
        end
    end

    // Sum in 33 bits, round half-up by adding 2^14, floor-shift back to Q1.15, then clamp.
    always_comb begin
        re_s     = $signed({s2_brwr_r[31], s2_brwr_r}) - $signed({s2_biwi_r[31], s2_biwi_r});
        im_s     = $signed({s2_brwi_r[31], s2_brwi_r}) + $signed({s2_biwr_r[31], s2_biwr_r});
        re_rnd_s = re_s + 33'sd16384;
        im_rnd_s = im_s + 33'sd16384;
        re_sh_s  = re_rnd_s >>> 15;
        im_sh_s  = im_rnd_s >>> 15;
        res_br_s = sat16(re_sh_s);
        res_bi_s = sat16(im_sh_s);
    end

    // S3: output register; holds everything while the downstream stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_ar_r    <= 16'd0;
            out_ai_r    <= 16'd0;
            out_br_r    <= 16'd0;
            out_bi_r    <= 16'd0;
            out_k_r     <= {KW{1'b0}};
        end else if (advance_s) begin
            out_valid_r <= s2_valid_r;
            if (s2_valid_r) begin
                out_ar_r <= s2_ar_r;
                out_ai_r <= s2_ai_r;
                out_br_r <= res_br_s;
                out_bi_r <= res_bi_s;
                out_k_r  <= s2_k_r;
            end
        end
    end

endmodule

// File: tb/tb_fft_twiddle_stage.sv
// Bench for fft_twiddle_stage: two N=8 instances (STRIDE 1 and 2) share stimulus and
// are checked against a floating-point twiddle model through an in-order scoreboard.
module tb_fft_twiddle_stage;

    logic        clk = 1'b0;
    logic        rst_n, in_valid, frame_start, out_ready;
    logic [15:0] in_ar, in_ai, in_br, in_bi;
    logic        in_ready, out_valid;
    logic [15:0] out_ar, out_ai, out_br, out_bi;
    logic [1:0]  out_k;
    logic        in_ready2, out_valid2;
    logic [15:0] o2_ar, o2_ai, o2_br, o2_bi;
    logic [1:0]  o2_k;

    always #5 clk = ~clk;

    fft_twiddle_stage #(.N(8), .STRIDE(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .frame_start(frame_start), .in_ar(in_ar), .in_ai(in_ai), .in_br(in_br), .in_bi(in_bi),
        .out_valid(out_valid), .out_ready(out_ready), .out_ar(out_ar), .out_ai(out_ai),
        .out_br(out_br), .out_bi(out_bi), .out_k(out_k));

    fft_twiddle_stage #(.N(8), .STRIDE(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
        .frame_start(frame_start), .in_ar(in_ar), .in_ai(in_ai), .in_br(in_br), .in_bi(in_bi),
        .out_valid(out_valid2), .out_ready(out_ready), .out_ar(o2_ar), .out_ai(o2_ai),
        .out_br(o2_br), .out_bi(o2_bi), .out_k(o2_k));

    typedef struct {
        logic [15:0] ar, ai, br1, bi1, br2, bi2;
        logic [1:0]  k1, k2;
    } exp_t;

    exp_t        sb[$];
    logic [1:0]  k1_log[$];
    logic [1:0]  k2_log[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          mk1 = 0;
    int          mk2 = 0;

    function automatic int rnd(real x);
        if (x >= 0.0) return $rtoi(x + 0.5);
        return -$rtoi(-x + 0.5);
    endfunction

    function automatic longint tw_re(int k);
        return longint'(rnd(32767.0 * $cos(2.0 * 3.14159265358979 * k / 8.0)));
    endfunction

    function automatic longint tw_im(int k);
        return longint'(rnd(-32767.0 * $sin(2.0 * 3.14159265358979 * k / 8.0)));
    endfunction

    function automatic logic [15:0] round_sat(longint v);
        longint r;
        r = (v + 64'sd16384) >>> 15;
        if (r > 64'sd32767) return 16'h7fff;
        if (r < -64'sd32768) return 16'h8000;
        return r[15:0];
    endfunction

    task automatic set_in(bit v, bit fs, int ar, int ai, int br, int bi);
        in_valid    = v;
        frame_start = fs;
        in_ar       = 16'(ar);
        in_ai       = 16'(ai);
        in_br       = 16'(br);
        in_bi       = 16'(bi);
    endtask

    // One clock: drain the scoreboard on a transfer, push the model result on an accept.
    task automatic tick();
        exp_t   e;
        int     ku1, ku2;
        longint br, bi;
        @(negedge clk);
        if (out_valid && out_ready) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL sb_underflow: got unexpected output k=%0d br=%h, required none", out_k, out_br);
            end else begin
                e = sb.pop_front();
                if ({out_valid2, out_ar, out_ai, out_br, out_bi, out_k, o2_ar, o2_ai, o2_br, o2_bi, o2_k} !==
                    {1'b1, e.ar, e.ai, e.br1, e.bi1, e.k1, e.ar, e.ai, e.br2, e.bi2, e.k2}) begin
                    n_err++;
                    $display("FAIL sb_data: got a=%h/%h b1=%h/%h k1=%0d b2=%h/%h k2=%0d v2=%b, required a=%h/%h b1=%h/%h k1=%0d b2=%h/%h k2=%0d",
                             out_ar, out_ai, out_br, out_bi, out_k, o2_br, o2_bi, o2_k, out_valid2,
                             e.ar, e.ai, e.br1, e.bi1, e.k1, e.br2, e.bi2, e.k2);
                end
                k1_log.push_back(out_k);
                k2_log.push_back(o2_k);
            end
        end
        if (in_valid && in_ready) begin
            ku1 = frame_start ? 0 : mk1;
            ku2 = frame_start ? 0 : mk2;
            mk1 = (ku1 + 1) % 4;
            mk2 = (ku2 + 2) % 4;
            br  = longint'($signed(in_br));
            bi  = longint'($signed(in_bi));
            e.ar  = in_ar;
            e.ai  = in_ai;
            e.k1  = 2'(ku1);
            e.k2  = 2'(ku2);
            e.br1 = round_sat(br * tw_re(ku1) - bi * tw_im(ku1));
            e.bi1 = round_sat(br * tw_im(ku1) + bi * tw_re(ku1));
            e.br2 = round_sat(br * tw_re(ku2) - bi * tw_im(ku2));
            e.bi2 = round_sat(br * tw_im(ku2) + bi * tw_re(ku2));
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        set_in(1'b0, 1'b0, 0, 0, 0, 0);
        out_ready = 1'b1;
        for (int i = 0; i < 20 && sb.size() > 0; i++) tick();
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain_timeout: got %0d pairs outstanding, required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_in(1'b0, 1'b0, 0, 0, 0, 0);
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({out_valid, in_ready, out_ar, out_ai, out_br, out_bi, out_k} !== {1'b0, 1'b1, 66'd0}) begin
            n_err++;
            $display("FAIL reset_state: got v=%b rdy=%b a=%h/%h b=%h/%h k=%0d, required v=0 rdy=1 all 0",
                     out_valid, in_ready, out_ar, out_ai, out_br, out_bi, out_k);
        end
        rst_n = 1'b1;
        mk1 = 0;
        mk2 = 0;
    endtask

    task automatic test_k1_product();
        set_in(1'b1, 1'b1, 0, 0, 0, 0);
        tick();
        set_in(1'b1, 1'b0, 7, 8, 16384, 0);
        tick();
        set_in(1'b0, 1'b0, 0, 0, 0, 0);
        tick();
        n_cmp++;
        if (!(out_valid === 1'b1 && out_k === 2'd0)) begin
            n_err++;
            $display("FAIL k1_latency_early: got v=%b k=%0d two cycles after accept, required dummy v=1 k=0", out_valid, out_k);
        end
        tick();
        n_cmp++;
        if ({out_valid, out_k, out_br, out_bi} !== {1'b1, 2'd1, 16'd11585, 16'hd2bf}) begin
            n_err++;
            $display("FAIL k1_product: got v=%b k=%0d br=%0d bi=%0d, required v=1 k=1 br=11585 bi=-11585",
                     out_valid, out_k, $signed(out_br), $signed(out_bi));
        end
        drain();
    endtask

    task automatic test_k0_rounding();
        set_in(1'b1, 1'b1, 123, -45, 1000, -2000);
        tick();
        set_in(1'b0, 1'b0, 0, 0, 0, 0);
        for (int i = 0; i < 6 && !out_valid; i++) tick();
        n_cmp++;
        if ({out_valid, out_ar, out_ai, out_br, out_bi, out_k} !==
            {1'b1, 16'd123, 16'hffd3, 16'd1000, 16'hf830, 2'd0}) begin
            n_err++;
            $display("FAIL k0_rounding: got v=%b a=%0d/%0d b=%0d/%0d k=%0d, required 1 123/-45 1000/-2000 0",
                     out_valid, $signed(out_ar), $signed(out_ai), $signed(out_br), $signed(out_bi), out_k);
        end
        drain();
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 4; i++) begin
            if (i == 3) set_in(1'b1, 1'b0, 1, 2, -32768, -32768);
            else        set_in(1'b1, i == 0, 0, 0, 100, 200);
            tick();
        end
        set_in(1'b0, 1'b0, 0, 0, 0, 0);
        for (int i = 0; i < 6 && !(out_valid && out_k == 2'd3); i++) tick();
        n_cmp++;
        if ({out_valid, out_k, out_br, out_bi} !== {1'b1, 2'd3, 16'd0, 16'd32767}) begin
            n_err++;
            $display("FAIL saturation: got v=%b k=%0d br=%0d bi=%0d, required 1 3 0 32767",
                     out_valid, out_k, $signed(out_br), $signed(out_bi));
        end
        drain();
    endtask

    task automatic test_index_seq();
        int exp_a[6] = '{0, 2, 0, 2, 0, 2};
        int exp_b[6] = '{0, 2, 0, 0, 2, 0};
        int ex;
        for (int run = 0; run < 2; run++) begin
            k2_log.delete();
            for (int i = 0; i < 6; i++) begin
                set_in(1'b1, (i == 0) || (run == 1 && i == 3),
                       int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)),
                       int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)));
                tick();
            end
            drain();
            n_cmp++;
            if (k2_log.size() != 6) begin
                n_err++;
                $display("FAIL index_count run%0d: got %0d outputs, required 6", run, k2_log.size());
            end else begin
                for (int i = 0; i < 6; i++) begin
                    ex = (run == 0) ? exp_a[i] : exp_b[i];
                    n_cmp++;
                    if (k2_log[i] !== 2'(ex)) begin
                        n_err++;
                        $display("FAIL index_seq run%0d pair%0d: got k=%0d, required %0d", run, i, k2_log[i], ex);
                    end
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int          sent = 0;
        bit          stall, acc;
        logic [68:0] snap;
        logic [15:0] d[4];
        for (int j = 0; j < 4; j++) d[j] = 16'($urandom);
        for (int cyc = 0; cyc < 300 && (sent < 8 || sb.size() > 0); cyc++) begin
            out_ready = 1'($urandom_range(0, 1));
            if (sent < 8) set_in(1'b1, sent == 0, int'(d[0]), int'(d[1]), int'(d[2]), int'(d[3]));
            else          set_in(1'b0, 1'b0, 0, 0, 0, 0);
            #1;
            n_cmp++;
            if (in_ready !== !(out_valid && !out_ready)) begin
                n_err++;
                $display("FAIL in_ready_rule: got %b with v=%b ordy=%b, required %b",
                         in_ready, out_valid, out_ready, !(out_valid && !out_ready));
            end
            stall = out_valid && !out_ready;
            snap  = {out_valid, out_ar, out_ai, out_br, out_bi, out_k, o2_k};
            acc   = in_valid && in_ready;
            tick();
            if (stall) begin
                n_cmp++;
                if ({out_valid, out_ar, out_ai, out_br, out_bi, out_k, o2_k} !== snap) begin
                    n_err++;
                    $display("FAIL stall_stable: got %h, required %h",
                             {out_valid, out_ar, out_ai, out_br, out_bi, out_k, o2_k}, snap);
                end
            end
            if (acc) begin
                sent++;
                for (int j = 0; j < 4; j++) d[j] = 16'($urandom);
            end
        end
        n_cmp++;
        if (sent != 8 || sb.size() != 0) begin
            n_err++;
            $display("FAIL bp_complete: got sent=%0d pending=%0d, required 8 and 0", sent, sb.size());
            sb.delete();
        end
        drain();
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, i == 0, 300 + i, 400 + i, 5000 + i, -6000 - i);
            tick();
        end
        set_in(1'b0, 1'b0, 0, 0, 0, 0);
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({out_valid, out_valid2, in_ready, out_ar, out_ai, out_br, out_bi, out_k} !== {3'b001, 66'd0}) begin
            n_err++;
            $display("FAIL reset_mid: got v=%b v2=%b rdy=%b a=%h/%h b=%h/%h k=%0d, required v=0 rdy=1 all 0",
                     out_valid, out_valid2, in_ready, out_ar, out_ai, out_br, out_bi, out_k);
        end
        sb.delete();
        mk1 = 0;
        mk2 = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++;
            if (out_valid !== 1'b0) begin
                n_err++;
                $display("FAIL reset_flush cycle%0d: got out_valid=%b, required 0", i, out_valid);
            end
        end
        k1_log.delete();
        k2_log.delete();
        set_in(1'b1, 1'b0, 11, 22, 8000, 4000);
        tick();
        drain();
        n_cmp++;
        if (k1_log.size() != 1 || k1_log[0] !== 2'd0 || k2_log[0] !== 2'd0) begin
            n_err++;
            $display("FAIL reset_k0: got %0d outputs k1=%0d k2=%0d, required 1 output k=0",
                     k1_log.size(), k1_log.size() > 0 ? k1_log[0] : 2'd3, k2_log.size() > 0 ? k2_log[0] : 2'd3);
        end
    endtask

    initial begin
        test_reset();
        test_k1_product();
        test_k0_rounding();
        test_saturation();
        test_index_seq();
        test_backpressure();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion by time limit, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
